// File: rtl/div32_pkg.sv
// Shared arithmetic definitions for the iterative divider.
// - div_state_e : FSM state encodings (DIV_IDLE, DIV_ITER, DIV_FIX)
// - DIV_ZERO_Q  : quotient returned for a zero divisor
// - INT_MIN     : most negative 32-bit two's complement value
// - neg_if()    : conditional two's complement negation (modulo 2^32)
package div32_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ITER = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div32_if.sv
// Execute-stage divider handshake bundle.
// master (issue side): flush, in_en, a, b, is_signed
// slave  (divider)   : idle, out_en, quotient, remainder
interface div32_if;
  logic        flush;
  logic        in_en;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic        idle;
  logic        out_en;
  logic [31:0] quotient;
  logic [31:0] remainder;

  modport master (
    output flush, in_en, a, b, is_signed,
    input  idle, out_en, quotient, remainder
  );

  modport slave (
    input  flush, in_en, a, b, is_signed,
    output idle, out_en, quotient, remainder
  );
endinterface

// File: rtl/div32_step.sv
// div_step: one combinational restoring-division step.
// rem_in  : 33-bit partial remainder
// dvd_bit : next dividend bit (MSB first)
// dvs     : 32-bit unsigned divisor
// rem_out : next partial remainder
// q_bit   : quotient bit produced by this step
module div_step (
  input  logic [32:0] rem_in,
  input  logic        dvd_bit,
  input  logic [31:0] dvs,
  output logic [32:0] rem_out,
  output logic        q_bit
);
  logic [33:0] shifted;
  logic [33:0] diff;
  logic        unused_msb;

  assign shifted = {rem_in, dvd_bit};
  assign diff    = shifted - {2'b00, dvs};
  assign q_bit   = (shifted >= {2'b00, dvs});
  // Remainder stays below the divisor, so bit 33 of the difference is never needed.
  assign rem_out = q_bit ? diff[32:0] : shifted[32:0];
  assign unused_msb = diff[33];
endmodule

// File: rtl/div32.sv
// div32: iterative 32-bit divider (DIV/DIVU/REM/REMU), non-pipelined.
// Ports: clk, rst_n (async active low), bus (div32_if.slave):
//   flush, in_en, a, b, is_signed in; idle, out_en, quotient, remainder out.
// Works on magnitudes with STEPS_PER_CYCLE restoring steps per clock and
// applies signs in a final FIX cycle. Zero divisor and signed overflow skip
// the iteration and go straight to FIX.
module div32
  import div32_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  div32_if.slave bus
);
  localparam int S  = STEPS_PER_CYCLE;
  localparam int N  = 32 / S;
  localparam int CW = $clog2(N + 1);

  div_state_e    state_q, state_d;
  logic          idle_q, idle_d;
  logic          out_en_q, out_en_d;
  logic [31:0]   quotient_q, quotient_d;
  logic [31:0]   remainder_q, remainder_d;
  logic [31:0]   dvd_q, dvd_d;     // dividend magnitude, quotient bits shift in at LSB
  logic [31:0]   dvs_q, dvs_d;     // divisor magnitude
  logic [32:0]   rem_q, rem_d;     // partial remainder
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_neg_q, q_neg_d;
  logic          r_neg_q, r_neg_d;
  logic          special_q, special_d;

  // Operand decode for the accepting cycle
  logic        sa, sb, div_zero, ovf;
  logic [31:0] a_mag, b_mag;

  assign sa       = bus.is_signed & bus.a[31];
  assign sb       = bus.is_signed & bus.b[31];
  assign a_mag    = neg_if(bus.a, sa);
  assign b_mag    = neg_if(bus.b, sb);
  assign div_zero = (bus.b == 32'd0);
  assign ovf      = bus.is_signed && (bus.a == INT_MIN) && (bus.b == DIV_ZERO_Q);

  // Step chain: step k consumes dividend bit 31-k this cycle
  logic [S:0][32:0] chain_rem;
  logic [S-1:0]     q_bits;
  logic [31:0]      dvd_next;

  assign chain_rem[0] = rem_q;

  for (genvar k = 0; k < S; k++) begin : g_step
    div_step u_step (
      .rem_in  (chain_rem[k]),
      .dvd_bit (dvd_q[31-k]),
      .dvs     (dvs_q),
      .rem_out (chain_rem[k+1]),
      .q_bit   (q_bits[S-1-k])
    );
  end

  assign dvd_next = {dvd_q[31-S:0], q_bits};

  always_comb begin
    state_d     = state_q;
    idle_d      = idle_q;
    out_en_d    = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    special_d   = special_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (bus.in_en && !bus.flush) begin
          idle_d    = 1'b0;
          dvs_d     = b_mag;
          q_neg_d   = sa ^ sb;
          r_neg_d   = sa;
          special_d = div_zero | ovf;
          cnt_d     = '0;
          if (div_zero) begin
            // Result preloaded; FIX passes it through without sign handling
            dvd_d   = DIV_ZERO_Q;
            rem_d   = {1'b0, bus.a};
            state_d = DIV_FIX;
          end else if (ovf) begin
            dvd_d   = INT_MIN;
            rem_d   = '0;
            state_d = DIV_FIX;
          end else begin
            dvd_d   = a_mag;
            rem_d   = '0;
            state_d = DIV_ITER;
          end
        end
      end

      DIV_ITER: begin
        rem_d = chain_rem[S];
        dvd_d = dvd_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = DIV_FIX;
      end

      DIV_FIX: begin
        quotient_d  = special_q ? dvd_q : neg_if(dvd_q, q_neg_q);
        remainder_d = special_q ? rem_q[31:0] : neg_if(rem_q[31:0], r_neg_q);
        out_en_d    = 1'b1;
        idle_d      = 1'b1;
        state_d     = DIV_IDLE;
      end

      default: state_d = DIV_IDLE;
    endcase

    // Flush wins over everything; published results are left untouched
    if (bus.flush) begin
      state_d     = DIV_IDLE;
      idle_d      = 1'b1;
      out_en_d    = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DIV_IDLE;
      idle_q      <= 1'b1;
      out_en_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      special_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      out_en_q    <= out_en_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      special_q   <= special_d;
    end
  end

  assign bus.idle      = idle_q;
  assign bus.out_en    = out_en_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
endmodule

// File: doc/div32.md
Name: div32

Overview:
- Iterative 32-bit integer divider for the execute stage.
- Complements the 4-cycle multiplier and covers the RISC-V M divide ops: DIV, DIVU, REM and REMU.
- Multi-cycle and non-pipelined: it accepts one operation while idle and returns quotient and remainder together.
- It uses the same handshake style as the multiplier: in_en to start, idle while able to accept, and an out_en result pulse.

Parameters:
STEPS_PER_CYCLE, 2, restoring-division steps done per clock; must be 1, 2 or 4. N = 32/STEPS_PER_CYCLE iteration cycles.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active low
flush  input  1  abort the current operation (pipeline flush)
in_en  input  1  start request; sampled only while idle=1
a  input  32  dividend
b  input  32  divisor
is_signed  input  1  1 = both operands are two's complement (DIV/REM), 0 = unsigned
idle  output  1  block can accept in_en this cycle
out_en  output  1  one-cycle pulse; quotient and remainder are valid
quotient  output  32  result quotient
remainder  output  32  result remainder

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, idle=1, out_en=0, quotient=0, remainder=0, internal registers cleared.
- A reset while an operation is in progress discards it; no out_en follows.
- States: IDLE, ITER, FIX.
- IDLE:
  - out_en<=0 unless it is being set this edge.
  - If in_en=1 and flush=0, accept the operation and set idle<=0.
  - Latch |a| and |b|. Magnitudes apply only when is_signed=1 and the MSB is set.
  - Latch q_neg = sa^sb and r_neg = sa, where sa/sb = is_signed & MSB.
  - Latch a special-case flag. Clear the partial remainder and count.
  - Normal operation: go to ITER.
  - Divide-by-zero or signed overflow: go directly to FIX.
- ITER:
  - Each edge performs STEPS_PER_CYCLE restoring steps on the unsigned magnitudes, MSB first.
  - Per step: shift the remainder left and bring in the next dividend bit; trial-subtract the divisor; if the result is non-negative, keep it and set the quotient bit to 1.
  - The partial remainder is 33 bits wide.
  - count increments each edge; after N edges, go to FIX.
- FIX:
  - Apply signs: negate the quotient if q_neg, negate the remainder if r_neg.
  - Register the results into quotient/remainder.
  - Set out_en<=1 and idle<=1, then return to IDLE.
- Latency, counted in edges from the accepting edge to the edge that raises out_en:
  - normal: N+1, i.e. 17 at the default;
  - special cases: 1.
- out_en lasts exactly one cycle.
- quotient/remainder hold their value until the next FIX; they do not change on flush.
- Special cases:
  - b=0 (signed or unsigned): quotient=0xFFFFFFFF, remainder=a.
  - Signed a=0x80000000 with b=0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Back-to-back: in the cycle where out_en=1, idle=1, so an in_en in that cycle is accepted on the next edge.
- in_en while idle=0 is ignored; it is neither queued nor reported as an error.
- flush=1:
  - Highest priority below reset. In any state, the next edge gives state=IDLE, idle=1, out_en=0.
  - flush together with in_en in IDLE: no accept.
  - flush in the FIX cycle: no out_en is produced.
- Negation is two's complement modulo 2^32. |0x80000000| is represented as unsigned 0x80000000.

Decomposition:
- Shared arith header with:
  - state encodings DIV_IDLE, DIV_ITER and DIV_FIX;
  - constants DIV_ZERO_Q = 32'hFFFFFFFF and INT_MIN = 32'h80000000.
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: 33-bit remainder, 1 dividend bit, 32-bit divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated STEPS_PER_CYCLE times in a chain inside div32.

Test Plan:
- Unsigned 100/7, is_signed=0 -> out_en exactly 17 edges after accept; quotient=14, remainder=2; idle low for the whole operation.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
- Special cases, each with out_en 1 edge after accept:
  - 5/0 unsigned -> quotient=0xFFFFFFFF, remainder=5;
  - signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0;
  - unsigned 0x80000000/0xFFFFFFFF -> quotient=0, remainder=0x80000000 after the full 17 edges.
- Flush and busy handling:
  - Start 1000/3, assert flush on the 5th ITER cycle -> idle=1 next cycle; no out_en ever; quotient/remainder unchanged from the previous result.
  - in_en pulses while busy -> ignored.
- Back-to-back: assert in_en for 0xFFFFFFFF/1 in the out_en cycle of a prior op -> accepted; second result quotient=0xFFFFFFFF, remainder=0.
- Async reset: drop rst_n mid-ITER between clock edges -> outputs are immediately idle=1, out_en=0, quotient=0, remainder=0.
- Randomised: 10k random operands with both is_signed values, at STEPS_PER_CYCLE in {1, 2, 4} -> results match the RISC-V reference model.
